pedestal_subtract: RTL and testbench

- Downstream consumer of the pedestal row buffer. Takes the live ADC pixel stream plus the pedestal value delivered in the same cycle, and produces offset-corrected, saturated pixels for the image path.
- Frames each row by pixel count, accumulates a per-row sum for AGC, and flags malformed rows.
- Single clock domain: the read-side clock of the pedestal buffer.

---
 rtl/pedestal_subtract_pkg.sv | 14 +
 rtl/ped_sub_pipe.sv | 71 +++++++
 rtl/pedestal_subtract.sv | 119 +++++++++++
 tb/tb_pedestal_subtract.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pedestal_subtract_pkg.sv
// Shared widths and FSM state type for the pedestal subtraction path.
package pedestal_subtract_pkg;

    localparam int unsigned ADC_WIDTH  = 14;
    localparam int unsigned PIX_IN_ROW = 640;
    localparam int unsigned ROW_SUM_W  = 24;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } state_t;

endpackage

// File: rtl/ped_sub_pipe.sv
// Two-stage pedestal subtract / offset / clamp datapath with valid, last and bypass pipelining.
module ped_sub_pipe
    import pedestal_subtract_pkg::*;
#(
    parameter int unsigned DATA_W = ADC_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [DATA_W-1:0] pix,
    input  logic [DATA_W-1:0] ped,
    input  logic [DATA_W-1:0] offset,
    input  logic              bypass,
    output logic              busy,
    output logic              out_valid,
    output logic              out_last,
    output logic [DATA_W-1:0] out_data
);

    logic              s1_valid;
    logic              s1_last;
    logic              s1_bypass;
    logic [DATA_W-1:0] s1_pix;
    logic [DATA_W:0]   s1_diff;
    logic [DATA_W+1:0] sum;
    logic [DATA_W-1:0] clamped;

    // Two's-complement sum: bit DATA_W+1 is the sign, bit DATA_W flags overflow past full scale.
    always_comb begin
        sum = {s1_diff[DATA_W], s1_diff} + {2'b00, offset};
        if (sum[DATA_W+1]) begin
            clamped = '0;
        end else if (sum[DATA_W]) begin
            clamped = '1;
        end else begin
            clamped = sum[DATA_W-1:0];
        end
    end

    assign busy = s1_valid | out_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_bypass <= 1'b0;
            s1_pix    <= '0;
            s1_diff   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            // Flush only kills stage 1 contents; a pixel presented alongside it still loads.
            s1_valid <= in_valid;
            s1_last  <= in_valid & in_last;
            if (in_valid) begin
                s1_diff   <= {1'b0, pix} - {1'b0, ped};
                s1_pix    <= pix;
                s1_bypass <= bypass;
            end
            out_valid <= s1_valid & ~flush;
            out_last  <= s1_last & ~flush;
            if (s1_valid && !flush) begin
                out_data <= s1_bypass ? s1_pix : clamped;
            end
        end
    end

endmodule

// File: rtl/pedestal_subtract.sv
// Row framing, per-row sum and malformed-row detection around the pedestal subtract datapath.
module pedestal_subtract
    import pedestal_subtract_pkg::*;
#(
    parameter int unsigned DATA_W     = ADC_WIDTH,
    parameter int unsigned PIX_IN_ROW = pedestal_subtract_pkg::PIX_IN_ROW,
    parameter int unsigned CNT_W      = 10,
    parameter int unsigned SUM_W      = ROW_SUM_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ROW_START,
    input  logic              PIX_VALID,
    input  logic [DATA_W-1:0] PIX_DATA,
    input  logic [DATA_W-1:0] PED_DATA,
    input  logic [DATA_W-1:0] OFFSET,
    input  logic              BYPASS,
    output logic              OUT_VALID,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              ROW_DONE,
    output logic [SUM_W-1:0]  ROW_SUM,
    output logic              ROW_ERR
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] acc_sum;
    logic             accept;
    logic             last_px;
    logic             short_row;
    logic             stray;
    logic             busy;
    logic             out_last;

    always_comb begin
        accept    = PIX_VALID && (state == ACTIVE || ROW_START);
        last_px   = accept && state == ACTIVE && !ROW_START
                    && cnt == CNT_W'(PIX_IN_ROW - 1);
        short_row = state == ACTIVE && ROW_START && (cnt != '0 || busy);
        stray     = PIX_VALID && !ROW_START && state != ACTIVE;
        acc_sum   = acc + SUM_W'(OUT_DATA);
    end

    ped_sub_pipe #(
        .DATA_W (DATA_W)
    ) u_pipe (
        .clk       (CLK),
        .reset     (RESET),
        .flush     (short_row),
        .in_valid  (accept),
        .in_last   (last_px),
        .pix       (PIX_DATA),
        .ped       (PED_DATA),
        .offset    (OFFSET),
        .bypass    (BYPASS),
        .busy      (busy),
        .out_valid (OUT_VALID),
        .out_last  (out_last),
        .out_data  (OUT_DATA)
    );

    // Row completion follows the tagged last pixel out of the pipe, so a row started
    // during DRAIN overlaps cleanly: the old sum is snapshotted before acc is reused.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            ROW_DONE <= 1'b0;
            ROW_SUM  <= '0;
            ROW_ERR  <= 1'b0;
        end else begin
            ROW_ERR  <= short_row | stray;
            ROW_DONE <= 1'b0;
            if (OUT_VALID && out_last) begin
                ROW_DONE <= 1'b1;
                ROW_SUM  <= acc_sum;
            end

            if (ROW_START && state != DRAIN) begin
                acc <= '0;
            end else if (OUT_VALID && out_last) begin
                acc <= '0;
            end else if (OUT_VALID) begin
                acc <= acc_sum;
            end

            case (state)
                IDLE: begin
                    if (ROW_START) begin
                        state <= ACTIVE;
                        cnt   <= CNT_W'(accept);
                    end
                end
                ACTIVE: begin
                    if (ROW_START) begin
                        cnt <= CNT_W'(accept);
                    end else if (last_px) begin
                        cnt   <= '0;
                        state <= DRAIN;
                    end else if (accept) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (ROW_START) begin
                        state <= ACTIVE;
                        cnt   <= CNT_W'(accept);
                    end else if (OUT_VALID && out_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pedestal_subtract.sv
// Directed self-checking bench for pedestal_subtract with an 8-pixel row and OFFSET=100.
module tb_pedestal_subtract;

    localparam int unsigned DW   = 14;
    localparam int unsigned SW   = 24;
    localparam int unsigned NPIX = 8;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          ROW_START;
    logic          PIX_VALID;
    logic [DW-1:0] PIX_DATA;
    logic [DW-1:0] PED_DATA;
    logic [DW-1:0] OFFSET;
    logic          BYPASS;
    logic          OUT_VALID;
    logic [DW-1:0] OUT_DATA;
    logic          ROW_DONE;
    logic [SW-1:0] ROW_SUM;
    logic          ROW_ERR;

    pedestal_subtract #(
        .DATA_W     (DW),
        .PIX_IN_ROW (NPIX),
        .CNT_W      (10),
        .SUM_W      (SW)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .ROW_START (ROW_START),
        .PIX_VALID (PIX_VALID),
        .PIX_DATA  (PIX_DATA),
        .PED_DATA  (PED_DATA),
        .OFFSET    (OFFSET),
        .BYPASS    (BYPASS),
        .OUT_VALID (OUT_VALID),
        .OUT_DATA  (OUT_DATA),
        .ROW_DONE  (ROW_DONE),
        .ROW_SUM   (ROW_SUM),
        .ROW_ERR   (ROW_ERR)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [DW-1:0] pix_v [NPIX];
    logic [DW-1:0] ped_v [NPIX];
    logic          byp_v [NPIX];
    int            in_cyc[NPIX];

    logic [DW-1:0] obs_od [64];
    int            obs_cyc[64];
    int            obs_n;
    logic [SW-1:0] done_sum[8];
    int            done_cyc[8];
    int            n_done;
    int            n_err;
    int            err_cyc;

    // Inputs are changed 1 time unit after an edge; outputs sampled at the same point.
    // A pixel captured by the edge at sample index k shows OUT_VALID at index k+1
    // (two cycles after it was presented) and its row's ROW_DONE at index k+2.
    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        if (OUT_VALID && obs_n < 64) begin
            obs_od[obs_n]  = OUT_DATA;
            obs_cyc[obs_n] = cyc;
            obs_n++;
        end
        if (ROW_DONE) begin
            if (n_done < 8) begin
                done_sum[n_done] = ROW_SUM;
                done_cyc[n_done] = cyc;
            end
            n_done++;
        end
        if (ROW_ERR) begin
            if (n_err == 0) err_cyc = cyc;
            n_err++;
        end
    endtask

    task automatic set_idle();
        ROW_START = 1'b0;
        PIX_VALID = 1'b0;
        PIX_DATA  = '0;
        PED_DATA  = '0;
        BYPASS    = 1'b0;
    endtask

    task automatic clear_obs();
        obs_n   = 0;
        n_done  = 0;
        n_err   = 0;
        err_cyc = -1;
    endtask

    task automatic idle(input int n);
        set_idle();
        repeat (n) tick();
    endtask

    task automatic fill(input logic [DW-1:0] pix, input logic [DW-1:0] ped, input logic byp);
        for (int i = 0; i < NPIX; i++) begin
            pix_v[i] = pix;
            ped_v[i] = ped;
            byp_v[i] = byp;
        end
    endtask

    task automatic send_row(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            ROW_START = (i == 0);
            PIX_VALID = 1'b1;
            PIX_DATA  = pix_v[i];
            PED_DATA  = ped_v[i];
            BYPASS    = byp_v[i];
            tick();
            in_cyc[i] = cyc;
            if (gap) begin
                set_idle();
                tick();
            end
        end
        set_idle();
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        set_idle();
        tick();
        tick();
        if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", OUT_VALID); end
        checks++;
        if (OUT_DATA !== '0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", OUT_DATA); end
        checks++;
        if (ROW_DONE !== 1'b0) begin errors++; $display("FAIL reset_row_done: got %b expected 0", ROW_DONE); end
        checks++;
        if (ROW_SUM !== '0) begin errors++; $display("FAIL reset_row_sum: got %0d expected 0", ROW_SUM); end
        checks++;
        if (ROW_ERR !== 1'b0) begin errors++; $display("FAIL reset_row_err: got %b expected 0", ROW_ERR); end
        checks++;
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_full_row();
        clear_obs();
        fill(14'd1000, 14'd900, 1'b0);
        send_row(NPIX, 1'b0);
        idle(4);
        if (obs_n !== NPIX) begin errors++; $display("FAIL full_out_count: got %0d expected %0d", obs_n, NPIX); end
        checks++;
        for (int i = 0; i < NPIX && i < obs_n; i++) begin
            if (obs_od[i] !== 14'd200) begin errors++; $display("FAIL full_data[%0d]: got %0d expected 200", i, obs_od[i]); end
            checks++;
            if (obs_cyc[i] !== in_cyc[i] + 1) begin errors++; $display("FAIL full_latency[%0d]: got %0d expected %0d", i, obs_cyc[i], in_cyc[i] + 1); end
            checks++;
        end
        if (n_done !== 1) begin errors++; $display("FAIL full_done_count: got %0d expected 1", n_done); end
        checks++;
        if (done_cyc[0] !== in_cyc[NPIX-1] + 2) begin errors++; $display("FAIL full_done_time: got %0d expected %0d", done_cyc[0], in_cyc[NPIX-1] + 2); end
        checks++;
        if (done_sum[0] !== 24'd1600) begin errors++; $display("FAIL full_row_sum: got %0d expected 1600", done_sum[0]); end
        checks++;
        if (ROW_SUM !== 24'd1600) begin errors++; $display("FAIL full_row_sum_hold: got %0d expected 1600", ROW_SUM); end
        checks++;
        if (n_err !== 0) begin errors++; $display("FAIL full_no_err: got %0d expected 0", n_err); end
        checks++;
        if (OUT_DATA !== 14'd200) begin errors++; $display("FAIL full_out_hold: got %0d expected 200", OUT_DATA); end
        checks++;
    endtask

    task automatic test_clamp();
        logic [DW-1:0] exp_v[NPIX];
        pix_v[0] = 14'd50;    ped_v[0] = 14'd500; exp_v[0] = 14'd0;
        pix_v[1] = 14'd16383; ped_v[1] = 14'd0;   exp_v[1] = 14'd16383;
        pix_v[2] = 14'd400;   ped_v[2] = 14'd500; exp_v[2] = 14'd0;
        pix_v[3] = 14'd16283; ped_v[3] = 14'd0;   exp_v[3] = 14'd16383;
        pix_v[4] = 14'd16283; ped_v[4] = 14'd1;   exp_v[4] = 14'd16382;
        pix_v[5] = 14'd0;     ped_v[5] = 14'd100; exp_v[5] = 14'd0;
        pix_v[6] = 14'd1;     ped_v[6] = 14'd100; exp_v[6] = 14'd1;
        pix_v[7] = 14'd1000;  ped_v[7] = 14'd900; exp_v[7] = 14'd200;
        for (int i = 0; i < NPIX; i++) byp_v[i] = 1'b0;
        clear_obs();
        send_row(NPIX, 1'b0);
        idle(4);
        if (obs_n !== NPIX) begin errors++; $display("FAIL clamp_out_count: got %0d expected %0d", obs_n, NPIX); end
        checks++;
        for (int i = 0; i < NPIX && i < obs_n; i++) begin
            if (obs_od[i] !== exp_v[i]) begin errors++; $display("FAIL clamp_data[%0d]: got %0d expected %0d", i, obs_od[i], exp_v[i]); end
            checks++;
        end
        if (done_sum[0] !== 24'd49349 || n_done !== 1) begin errors++; $display("FAIL clamp_row_sum: got %0d (done=%0d) expected 49349", done_sum[0], n_done); end
        checks++;
    endtask

    task automatic test_bypass();
        logic [DW-1:0] exp_v[NPIX];
        fill(14'd1234, 14'd1000, 1'b0);
        byp_v[0] = 1'b1; byp_v[1] = 1'b1; byp_v[4] = 1'b1; byp_v[6] = 1'b1;
        for (int i = 0; i < NPIX; i++) exp_v[i] = byp_v[i] ? 14'd1234 : 14'd334;
        clear_obs();
        send_row(NPIX, 1'b0);
        idle(4);
        if (obs_n !== NPIX) begin errors++; $display("FAIL bypass_out_count: got %0d expected %0d", obs_n, NPIX); end
        checks++;
        for (int i = 0; i < NPIX && i < obs_n; i++) begin
            if (obs_od[i] !== exp_v[i]) begin errors++; $display("FAIL bypass_data[%0d]: got %0d expected %0d", i, obs_od[i], exp_v[i]); end
            checks++;
        end
        if (done_sum[0] !== 24'd6272) begin errors++; $display("FAIL bypass_row_sum: got %0d expected 6272", done_sum[0]); end
        checks++;
    endtask

    task automatic test_short_row();
        clear_obs();
        fill(14'd1000, 14'd900, 1'b0);
        send_row(5, 1'b0);
        fill(14'd2000, 14'd900, 1'b0);
        send_row(NPIX, 1'b0);
        idle(4);
        if (n_err !== 1) begin errors++; $display("FAIL short_err_count: got %0d expected 1", n_err); end
        checks++;
        if (err_cyc !== in_cyc[0]) begin errors++; $display("FAIL short_err_time: got %0d expected %0d", err_cyc, in_cyc[0]); end
        checks++;
        if (n_done !== 1) begin errors++; $display("FAIL short_done_count: got %0d expected 1", n_done); end
        checks++;
        if (obs_n !== 12) begin errors++; $display("FAIL short_out_count: got %0d expected 12", obs_n); end
        checks++;
        for (int i = 4; i < 12 && i < obs_n; i++) begin
            if (obs_od[i] !== 14'd1200) begin errors++; $display("FAIL short_new_data[%0d]: got %0d expected 1200", i, obs_od[i]); end
            checks++;
        end
        if (done_sum[0] !== 24'd9600) begin errors++; $display("FAIL short_row_sum: got %0d expected 9600", done_sum[0]); end
        checks++;
    endtask

    task automatic test_stray();
        clear_obs();
        PIX_VALID = 1'b1;
        PIX_DATA  = 14'd1000;
        PED_DATA  = 14'd900;
        tick();
        idle(4);
        if (n_err !== 1) begin errors++; $display("FAIL stray_idle_err: got %0d expected 1", n_err); end
        checks++;
        if (obs_n !== 0) begin errors++; $display("FAIL stray_idle_out: got %0d expected 0", obs_n); end
        checks++;
        if (n_done !== 0 || ROW_SUM !== 24'd9600) begin errors++; $display("FAIL stray_idle_sum: got %0d (done=%0d) expected 9600", ROW_SUM, n_done); end
        checks++;

        clear_obs();
        fill(14'd1000, 14'd900, 1'b0);
        send_row(NPIX, 1'b0);
        PIX_VALID = 1'b1;
        PIX_DATA  = 14'd3000;
        PED_DATA  = 14'd0;
        tick();
        idle(4);
        if (n_err !== 1) begin errors++; $display("FAIL stray_drain_err: got %0d expected 1", n_err); end
        checks++;
        if (err_cyc !== in_cyc[NPIX-1] + 1) begin errors++; $display("FAIL stray_drain_err_time: got %0d expected %0d", err_cyc, in_cyc[NPIX-1] + 1); end
        checks++;
        if (obs_n !== NPIX) begin errors++; $display("FAIL stray_drain_out: got %0d expected %0d", obs_n, NPIX); end
        checks++;
        if (n_done !== 1 || done_sum[0] !== 24'd1600) begin errors++; $display("FAIL stray_drain_sum: got %0d (done=%0d) expected 1600", done_sum[0], n_done); end
        checks++;
    endtask

    task automatic test_gapped();
        clear_obs();
        fill(14'd1000, 14'd900, 1'b0);
        send_row(NPIX, 1'b1);
        idle(4);
        if (obs_n !== NPIX) begin errors++; $display("FAIL gap_out_count: got %0d expected %0d", obs_n, NPIX); end
        checks++;
        for (int i = 0; i < NPIX && i < obs_n; i++) begin
            if (obs_od[i] !== 14'd200 || obs_cyc[i] !== in_cyc[i] + 1) begin
                errors++;
                $display("FAIL gap_data[%0d]: got %0d at %0d expected 200 at %0d", i, obs_od[i], obs_cyc[i], in_cyc[i] + 1);
            end
            checks++;
        end
        if (n_done !== 1 || done_cyc[0] !== in_cyc[NPIX-1] + 2) begin errors++; $display("FAIL gap_done_time: got %0d (done=%0d) expected %0d", done_cyc[0], n_done, in_cyc[NPIX-1] + 2); end
        checks++;
        if (done_sum[0] !== 24'd1600 || n_err !== 0) begin errors++; $display("FAIL gap_row_sum: got %0d (err=%0d) expected 1600", done_sum[0], n_err); end
        checks++;
    endtask

    task automatic test_back_to_back();
        int a_last;
        clear_obs();
        fill(14'd1000, 14'd900, 1'b0);
        send_row(NPIX, 1'b0);
        a_last = in_cyc[NPIX-1];
        fill(14'd2000, 14'd900, 1'b0);
        send_row(NPIX, 1'b0);
        idle(5);
        if (n_done !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", n_done); end
        checks++;
        if (done_cyc[0] !== a_last + 2) begin errors++; $display("FAIL b2b_first_done_time: got %0d expected %0d", done_cyc[0], a_last + 2); end
        checks++;
        if (done_sum[0] !== 24'd1600) begin errors++; $display("FAIL b2b_first_sum: got %0d expected 1600", done_sum[0]); end
        checks++;
        if (done_sum[1] !== 24'd9600) begin errors++; $display("FAIL b2b_second_sum: got %0d expected 9600", done_sum[1]); end
        checks++;
        if (obs_n !== 16 || n_err !== 0) begin errors++; $display("FAIL b2b_out_count: got %0d (err=%0d) expected 16", obs_n, n_err); end
        checks++;
    endtask

    task automatic test_reset_mid();
        clear_obs();
        fill(14'd1000, 14'd900, 1'b0);
        send_row(4, 1'b0);
        RESET     = 1'b1;
        PIX_VALID = 1'b1;
        PIX_DATA  = 14'd1000;
        PED_DATA  = 14'd900;
        tick();
        if (OUT_VALID !== 1'b0 || OUT_DATA !== '0) begin errors++; $display("FAIL rstmid_out: got valid=%b data=%0d expected 0", OUT_VALID, OUT_DATA); end
        checks++;
        if (ROW_DONE !== 1'b0 || ROW_ERR !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got done=%b err=%b expected 0", ROW_DONE, ROW_ERR); end
        checks++;
        if (ROW_SUM !== '0) begin errors++; $display("FAIL rstmid_sum: got %0d expected 0", ROW_SUM); end
        checks++;
        RESET = 1'b0;
        clear_obs();
        idle(3);
        if (n_done !== 0 || n_err !== 0 || obs_n !== 0) begin errors++; $display("FAIL rstmid_quiet: got done=%0d err=%0d out=%0d expected 0", n_done, n_err, obs_n); end
        checks++;
        clear_obs();
        send_row(NPIX, 1'b0);
        idle(4);
        if (obs_n !== NPIX || n_err !== 0) begin errors++; $display("FAIL rstmid_row_out: got %0d (err=%0d) expected %0d", obs_n, n_err, NPIX); end
        checks++;
        if (n_done !== 1 || done_sum[0] !== 24'd1600) begin errors++; $display("FAIL rstmid_row_sum: got %0d (done=%0d) expected 1600", done_sum[0], n_done); end
        checks++;
    endtask

    initial begin
        RESET  = 1'b1;
        OFFSET = 14'd100;
        set_idle();
        clear_obs();
        test_reset();
        test_full_row();
        test_clamp();
        test_bypass();
        test_short_row();
        test_stray();
        test_gapped();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
